// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int unsigned RF_MAX_RD = 4;

  function automatic int unsigned rf_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: sweeps every entry once with zero, then holds READY
// until the next reset.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = rf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Sweep sequencing; the counter stops at the last entry so it never wraps.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_we       = 1'b0;
    case (state)
      RF_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_next = RF_READY;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      RF_READY: begin
      end
      default: state_next = RF_CLEAR;
    endcase
  end

  assign clr_addr = clr_cnt;
  assign ready    = (state == RF_READY);

endmodule

// File: rtl/regfile_multiport.sv
// NUM_RD-read / 1-write register file with registered reads, optional hardwired
// zero register, and a counted clear sweep after reset.
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding to reads).
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned DEPTH    = 32,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W   = rf_addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  output logic                     ready,
  output logic                     write_dropped
);

  if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
    $error("regfile_multiport: NUM_RD out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wr_zero = (ZERO_REG != 0) && (write_reg == '0);

  // Single physical write port shared between the clear sweep and user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = '0;
    if (!ready) begin
      mem_we = clr_we;
    end else if (write_enable && !wr_zero) begin
      mem_we    = 1'b1;
      mem_waddr = write_reg;
      mem_wdata = write_data;
    end
  end

  // Array write; no reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Flag user writes that arrive while the sweep owns the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= write_enable && !ready;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic user_wr;
  assign user_wr = ready && write_enable && !wr_zero;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              rd_zero;
    logic [DATA_W-1:0] data_q;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_zero = (ZERO_REG != 0) && (addr == '0);

    // Registered read; the zero rule outranks forwarding.
    always_ff @(posedge clk) begin
      if (reset || !ready) begin
        data_q <= '0;
      end else if (rd_zero) begin
        data_q <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (user_wr && (addr == write_reg)) begin
        data_q <= write_data;
`endif
      end else begin
        data_q <= mem[addr];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_q;
  end

endmodule
